demux_deser8: RTL and testbench
===============================

# demux_deser8

Serial-in, parallel-out 1:8 demultiplexer: the receive end of a link whose transmitter drives one bit per cycle through an 8:1 select mux stepping `sel` 0..7. The block tracks the slot index itself, steers each accepted bit into output lane `sel`, and presents each completed 8-bit word on a valid/ready output port. It sits between the serial link and the byte-wide consumer logic.

## Interface
- `REVERSE`, default 0: 0 puts slot k in `out[k]`; 1 puts slot k in `out[7-k]`.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in` input 1: serial data bit.
- `in_valid` input 1: `in` is accepted on any edge where this is 1.
- `frame_start` input 1: qualified by `in_valid`; marks the accepted bit as slot 0.
- `out` output 8: completed word from the holding register.
- `out_valid` output 1: `out` holds an unconsumed word.
- `out_ready` input 1: consumer accepts `out` when `out_valid && out_ready`.
- `sel` output 3: slot index the next accepted bit is written to.
- `overrun` output 1: one-cycle pulse; a completed word was dropped.
- `sync_err` output 1: one-cycle pulse; `frame_start` arrived mid-word.

## Operation
- States: IDLE (no frame alignment) and SHIFT (aligned). Reset enters IDLE.
- Reset values: `out`=8'h00, `out_valid`=0, `sel`=0, `overrun`=0, `sync_err`=0. The shadow register clears to 0.
- IDLE:
  - Bits with `in_valid && !frame_start` are discarded.
  - On `in_valid && frame_start`, the bit is written to shadow lane 0, `sel`←1, and the state moves to SHIFT.
- SHIFT, with `in_valid`:
  - The bit is written to shadow lane `sel` (mapped by `REVERSE`), and `sel`←`sel`+1 modulo 8.
  - When `sel` was 7, the word is complete. The shadow word with bit 7 merged in moves to the holding register, `sel` wraps to 0, and the state stays in SHIFT for back-to-back frames.
- SHIFT, no `in_valid`: everything holds, and `sel` does not advance.
- `frame_start` in SHIFT:
  - With `sel`=0: a normal boundary, no error.
  - With `sel`≠0: the partial word is abandoned and the shadow is cleared. The bit is written to lane 0, `sel`←1, and `sync_err` pulses.
- Holding register load:
  - The word loads if `out_valid`=0, or if `out_valid && out_ready` on the same edge (simultaneous consume and load). `out_valid` stays 1 when loading.
  - If `out_valid && !out_ready` at completion, the new word is dropped, `out` is unchanged, and `overrun` pulses.
- Consume without completion: `out_valid`←0 and `out` holds its last value.
- Output stability: `out` changes only on a load.
- Reset mid-operation: it discards the partial word and the pending output, and returns to IDLE. A `frame_start` on the reset cycle is ignored.

## Timing
- Each bit is sampled on the edge where `in_valid`=1. `sel` reflects the new slot one cycle later.
- Latency from the 8th bit's edge to `out`/`out_valid` visible is 1 cycle (registered output, no combinational path from `in` to `out`).
- Sustained throughput is one word per 8 `in_valid` cycles, with zero bubbles, provided the consumer drains within 8 cycles.
- `overrun` and `sync_err` are registered pulses, high for exactly the cycle after the causing edge.
- `out_ready` is sampled only while `out_valid`=1. It has no combinational path to any output.

## Test plan
- **Reset and discard:** after reset, drive `in_valid`=1 with `in`=1 and `frame_start`=0 for 10 cycles. Required: `out_valid`=0 and `sel`=0 throughout, `out`=8'h00.
- **Single word:** with `REVERSE`=0 and `out_ready`=1, send `frame_start` with bits 1,0,1,0,0,1,0,1 (slots 0..7). Required: 1 cycle after the 8th bit, `out`=8'hA5 with `out_valid`=1 for one cycle, and `sel` back at 0.
- **Back-to-back with gaps:** send 8'h3C then 8'hC3 with idle `in_valid` gaps inserted. Required: words 8'h3C then 8'hC3 in order, with `sel` holding during the gaps.
- **Overrun:** hold `out_ready`=0 and send 8'h11 then 8'h22. Required: `out`=8'h11 stays, `overrun` pulses once after the second word. Then raise `out_ready`: `out_valid` falls and 8'h22 never appears.
- **Simultaneous consume and load:** with 8'h11 pending, raise `out_ready` on the same edge the 8th bit of 8'h22 arrives. Required: `out`=8'h22 and `out_valid` stays 1 with no drop pulse.
- **Resync:** send 3 bits, then `frame_start` followed by 8'h5A. Required: `sync_err` pulses once, output 8'h5A. Repeat with `REVERSE`=1: output 8'h5A bit-reversed, i.e. 8'h5A.

Source files
------------

// File: rtl/demux_deser8_if.sv
// demux_deser8_if: serial-in / word-out bundle for the 1:8 deserialiser.
//   in, in_valid, frame_start : serial link side (driven by master)
//   out, out_valid, out_ready : word output handshake (out_ready driven by master)
//   sel                       : slot index the next accepted bit lands in
//   overrun, sync_err         : one-cycle error pulses
// The slave modport is the deserialiser's view; master is the link/consumer view.
interface demux_deser8_if;
    logic       in;
    logic       in_valid;
    logic       frame_start;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] sel;
    logic       overrun;
    logic       sync_err;

    modport master (
        output in, in_valid, frame_start, out_ready,
        input  out, out_valid, sel, overrun, sync_err
    );

    modport slave (
        input  in, in_valid, frame_start, out_ready,
        output out, out_valid, sel, overrun, sync_err
    );
endinterface

// File: rtl/demux_deser8.sv
// demux_deser8: 1:8 serial-to-parallel demultiplexer with valid/ready word output.
//   clk    : single clock, rising edge
//   rst    : synchronous active-high reset
//   bus    : demux_deser8_if.slave (serial input, word output, sel, error pulses)
//   REVERSE: 0 puts slot k in out[k], 1 puts slot k in out[7-k]
// Bits accumulate in a shadow register; the completed word moves to a holding
// register that is only written on a load, so out stays stable otherwise.
module demux_deser8 #(
    parameter bit REVERSE = 1'b0
) (
    input logic          clk,
    input logic          rst,
    demux_deser8_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] out_q, out_d;
    logic       out_valid_q, out_valid_d;
    logic       overrun_q, overrun_d;
    logic       sync_err_q, sync_err_d;

    logic       start, resync, shift, complete, consume;
    logic [7:0] shadow_wr;

    function automatic logic [2:0] lane(input logic [2:0] slot);
        return REVERSE ? (3'd7 - slot) : slot;
    endfunction

    localparam logic [2:0] Lane0 = REVERSE ? 3'd7 : 3'd0;

    always_comb begin
        start    = (state_q == StIdle) && bus.in_valid && bus.frame_start;
        // frame_start at sel 0 is an ordinary boundary and is handled as a normal shift
        resync   = (state_q == StShift) && bus.in_valid && bus.frame_start && (sel_q != 3'd0);
        shift    = (state_q == StShift) && bus.in_valid && !resync;
        complete = shift && (sel_q == 3'd7);
        consume  = out_valid_q && bus.out_ready;
        // shadow with the current bit merged in; on completion this is the finished word
        shadow_wr              = shadow_q;
        shadow_wr[lane(sel_q)] = bus.in;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sel_q       <= 3'd0;
            shadow_q    <= 8'h00;
            out_q       <= 8'h00;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            shadow_q    <= shadow_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            sync_err_q  <= sync_err_d;
        end
    end

    // Next-state logic: once aligned, stays aligned until reset
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = StShift;
        end
    end

    // Datapath and output next values
    always_comb begin
        sel_d       = sel_q;
        shadow_d    = shadow_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        overrun_d   = 1'b0;
        sync_err_d  = 1'b0;

        if (start || resync) begin
            shadow_d        = 8'h00;
            shadow_d[Lane0] = bus.in;
            sel_d           = 3'd1;
            sync_err_d      = resync;
        end else if (shift) begin
            shadow_d = shadow_wr;
            sel_d    = sel_q + 3'd1;
        end

        if (consume) begin
            out_valid_d = 1'b0;
        end

        if (complete) begin
            if (!out_valid_q || bus.out_ready) begin
                out_d       = shadow_wr;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sel       = sel_q;
    assign bus.overrun   = overrun_q;
    assign bus.sync_err  = sync_err_q;

endmodule

// File: tb/tb_demux_deser8.sv
// tb_demux_deser8: drives identical stimulus into a REVERSE=0 and a REVERSE=1
// instance; completed words are checked against per-instance scoreboards at
// each output handshake, plus direct checks of sel, pulses and reset state.
module tb_demux_deser8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    demux_deser8_if b0();
    demux_deser8_if b1();

    demux_deser8 #(.REVERSE(1'b0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    demux_deser8 #(.REVERSE(1'b1)) u1 (.clk(clk), .rst(rst), .bus(b1));

    int n_vec = 0;
    int n_err = 0;
    int ov0 = 0, ov1 = 0, se0 = 0, se1 = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    typedef struct {
        logic [7:0] data;
        int         gap;
        logic [7:0] exp0;
        logic [7:0] exp1;
    } vec_t;

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7 - i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_chk(input string name, input logic [7:0] act, input bit is_rev);
        logic [7:0] e;
        if (is_rev ? (q1.size() == 0) : (q0.size() == 0)) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got unexpected word %0h expected none", name, act);
        end else begin
            e = is_rev ? q1.pop_front() : q0.pop_front();
            chk(name, {24'd0, act}, {24'd0, e});
        end
    endtask

    // Scoreboard monitor: a word is consumed on each handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (b0.overrun)  ov0++;
            if (b1.overrun)  ov1++;
            if (b0.sync_err) se0++;
            if (b1.sync_err) se1++;
            if (b0.out_valid && b0.out_ready) pop_chk("sb word rev0", b0.out, 1'b0);
            if (b1.out_valid && b1.out_ready) pop_chk("sb word rev1", b1.out, 1'b1);
        end
    end

    // Inputs change 1 time unit after a rising edge; they are consumed on the next one
    task automatic drive(input bit v, input bit fs, input bit b, input bit rdy);
        @(posedge clk);
        #1;
        b0.in_valid = v; b0.frame_start = fs; b0.in = b; b0.out_ready = rdy;
        b1.in_valid = v; b1.frame_start = fs; b1.in = b; b1.out_ready = rdy;
    endtask

    task automatic send_word(input logic [7:0] d, input int gap, input bit rdy,
                             input bit rdy_last, input bit push,
                             input logic [7:0] e0, input logic [7:0] e1);
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, k == 0, d[k], (k == 7) ? rdy_last : rdy);
            if (k == 7 && push) begin
                q0.push_back(e0);
                q1.push_back(e1);
            end
            if (k < 7) begin
                for (int g = 0; g < gap; g++) begin
                    drive(1'b0, 1'b0, 1'b0, rdy);
                    chk("gap sel rev0", {29'd0, b0.sel}, k + 1);
                    chk("gap sel rev1", {29'd0, b1.sel}, k + 1);
                end
            end
        end
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{data: 8'h3C, gap: 2, exp0: 8'h3C, exp1: 8'h3C};
        vecs[1] = '{data: 8'hC3, gap: 1, exp0: 8'hC3, exp1: 8'hC3};
        vecs[2] = '{data: 8'h01, gap: 0, exp0: 8'h01, exp1: 8'h80};
        vecs[3] = '{data: 8'hB1, gap: 0, exp0: 8'hB1, exp1: 8'h8D};
        vecs[4] = '{data: 8'h0F, gap: 3, exp0: 8'h0F, exp1: 8'hF0};
        vecs[5] = '{data: 8'hFF, gap: 0, exp0: 8'hFF, exp1: 8'hFF};

        b0.in_valid = 0; b0.frame_start = 0; b0.in = 0; b0.out_ready = 0;
        b1.in_valid = 0; b1.frame_start = 0; b1.in = 0; b1.out_ready = 0;

        // Reset state
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("reset out",       {24'd0, b0.out}, 32'h00);
        chk("reset out_valid", {31'd0, b0.out_valid}, 0);
        chk("reset sel",       {29'd0, b0.sel}, 0);
        chk("reset overrun",   {31'd0, b0.overrun}, 0);
        chk("reset sync_err",  {31'd0, b1.sync_err}, 0);

        // Unaligned bits are discarded
        for (int i = 0; i < 11; i++) begin
            drive(i < 10, 1'b0, 1'b1, 1'b1);
            chk("discard sel",       {29'd0, b0.sel}, 0);
            chk("discard out_valid", {31'd0, b0.out_valid}, 0);
            chk("discard out",       {24'd0, b1.out}, 32'h00);
        end

        // Single word, one-cycle latency
        send_word(8'hA5, 0, 1'b1, 1'b1, 1'b1, 8'hA5, rev8(8'hA5));
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("single out",       {24'd0, b0.out}, 32'hA5);
        chk("single out_valid", {31'd0, b0.out_valid}, 1);
        chk("single sel",       {29'd0, b0.sel}, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("single drained",   {31'd0, b0.out_valid}, 0);
        chk("single out hold",  {24'd0, b0.out}, 32'hA5);

        // Table of back-to-back words, some with gaps
        for (int i = 0; i < 6; i++) begin
            send_word(vecs[i].data, vecs[i].gap, 1'b1, 1'b1, 1'b1, vecs[i].exp0, vecs[i].exp1);
        end
        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("table sb empty rev0", q0.size(), 0);
        chk("table sb empty rev1", q1.size(), 0);
        chk("boundary no sync_err", se0, 0);

        // Overrun: second word dropped while first is pending
        send_word(8'h11, 0, 1'b0, 1'b0, 1'b1, 8'h11, rev8(8'h11));
        send_word(8'h22, 0, 1'b0, 1'b0, 1'b0, 8'h22, rev8(8'h22));
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("overrun pulse",     {31'd0, b0.overrun}, 1);
        chk("overrun pulse rev1", {31'd0, b1.overrun}, 1);
        chk("overrun out kept",  {24'd0, b0.out}, 32'h11);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("overrun pulse end", {31'd0, b0.overrun}, 0);
        chk("overrun out_valid", {31'd0, b0.out_valid}, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("overrun drained",   {31'd0, b0.out_valid}, 0);
        chk("overrun no 22",     {24'd0, b0.out}, 32'h11);
        chk("overrun count",     ov0, 1);

        // Simultaneous consume and load
        send_word(8'h11, 0, 1'b0, 1'b0, 1'b1, 8'h11, rev8(8'h11));
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'h22, 0, 1'b0, 1'b1, 1'b1, 8'h22, rev8(8'h22));
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("simul out",       {24'd0, b0.out}, 32'h22);
        chk("simul out rev1",  {24'd0, b1.out}, 32'h44);
        chk("simul out_valid", {31'd0, b0.out_valid}, 1);
        chk("simul no drop",   {31'd0, b0.overrun}, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("simul drained",   {31'd0, b0.out_valid}, 0);
        chk("simul ov count",  ov1, 1);

        // Resync: frame_start after three bits
        for (int k = 0; k < 3; k++) drive(1'b1, k == 0, 1'b1, 1'b1);
        send_word(8'h5A, 0, 1'b1, 1'b1, 1'b1, 8'h5A, 8'h5A);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("resync out",      {24'd0, b0.out}, 32'h5A);
        chk("resync out rev1", {24'd0, b1.out}, 32'h5A);
        chk("resync sync_err", se0, 1);
        for (int k = 0; k < 3; k++) drive(1'b1, k == 0, 1'b0, 1'b1);
        send_word(8'hB1, 0, 1'b1, 1'b1, 1'b1, 8'hB1, 8'h8D);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("resync2 out rev1", {24'd0, b1.out}, 32'h8D);
        chk("resync2 sync_err", se1, 2);

        // Reset mid-word, frame_start on the reset cycle ignored
        for (int k = 0; k < 4; k++) drive(1'b1, k == 0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("midrst sel",       {29'd0, b0.sel}, 0);
        chk("midrst out_valid", {31'd0, b0.out_valid}, 0);
        chk("midrst out",       {24'd0, b0.out}, 32'h00);
        send_word(8'h96, 1, 1'b1, 1'b1, 1'b1, 8'h96, rev8(8'h96));
        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b1);

        chk("final sb empty rev0", q0.size(), 0);
        chk("final sb empty rev1", q1.size(), 0);
        chk("final ov count",      ov0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
